// File: rtl/axil_csr_fifo_shell.sv
// Generic circular FIFO with explicit occupancy count.
// Latency: enqueued data visible at the head the cycle after the write.
// Backpressure: enq_rdy low when full, deq_vld low when empty; no bypass.
module simple_fifo #(
  parameter int els_p   = 4,
  parameter int width_p = 32,
  parameter int cnt_w_p = $clog2(els_p + 1)
) (
  input  logic               core_clk,
  input  logic               arst_n,
  input  logic               enq_vld,
  input  logic [width_p-1:0] enq_dat,
  output logic               enq_rdy,
  output logic               deq_vld,
  output logic [width_p-1:0] deq_dat,
  input  logic               deq_rdy,
  output logic [cnt_w_p-1:0] count
);
  localparam int ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] wr_ptr, rd_ptr;
  logic                enq, deq;

  assign enq_rdy = (count != cnt_w_p'(els_p));
  assign deq_vld = (count != '0);
  assign enq     = enq_vld & enq_rdy;
  assign deq     = deq_rdy & deq_vld;
  assign deq_dat = mem[rd_ptr];

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + ptr_w_lp'(1);
      if (deq) rd_ptr <= rd_ptr + ptr_w_lp'(1);
      if (enq && !deq)      count <= count + cnt_w_p'(1);
      else if (deq && !enq) count <= count - cnt_w_p'(1);
    end
  end

  always_ff @(posedge core_clk) begin
    if (enq) mem[wr_ptr] <= enq_dat;
  end
endmodule

// AXI4-Lite slave: CSR bank plus PS->PL / PL->PS FIFO channels with occupancy.
// Latency: write commits and read data return one cycle after the last handshake.
// Backpressure: one write and one read outstanding; readies drop until B/R handshakes.
module axil_csr_fifo_shell #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10,
  parameter int num_regs_p  = 4,
  parameter int num_ps2pl_p = 1,
  parameter int num_pl2ps_p = 1,
  parameter int fifo_els_p  = 4
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [2:0]                        s_axi_awprot,
  input  logic                              s_axi_awvalid,
  output logic                              s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                              s_axi_wvalid,
  output logic                              s_axi_wready,
  output logic [1:0]                        s_axi_bresp,
  output logic                              s_axi_bvalid,
  input  logic                              s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [2:0]                        s_axi_arprot,
  input  logic                              s_axi_arvalid,
  output logic                              s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                        s_axi_rresp,
  output logic                              s_axi_rvalid,
  input  logic                              s_axi_rready,
  output logic [num_regs_p*32-1:0]          csr_o,
  output logic [num_regs_p-1:0]             csr_wr_o,
  output logic [num_ps2pl_p*32-1:0]         ps2pl_data_o,
  output logic [num_ps2pl_p-1:0]            ps2pl_v_o,
  input  logic [num_ps2pl_p-1:0]            ps2pl_yumi_i,
  input  logic [num_pl2ps_p*32-1:0]         pl2ps_data_i,
  input  logic [num_pl2ps_p-1:0]            pl2ps_v_i,
  output logic [num_pl2ps_p-1:0]            pl2ps_ready_o
);
  localparam int cw = $clog2(fifo_els_p + 1);
  localparam int sw = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [6:0] nregs_lp  = 7'(num_regs_p);
  localparam logic [6:0] nps2pl_lp = 7'(num_ps2pl_p);
  localparam logic [6:0] npl2ps_lp = 7'(num_pl2ps_p);
  localparam logic [1:0] resp_okay   = 2'b00;
  localparam logic [1:0] resp_slverr = 2'b10;

  typedef struct packed {
    logic       csr;
    logic       ps2pl;
    logic       pl2ps;
    logic       occ;
    logic [5:0] idx;
  } dec_t;

  function automatic dec_t decode(input logic [7:0] w);
    dec_t d;
    d     = '0;
    d.idx = w[5:0];
    case (w[7:6])
      2'b00:   d.csr   = ({1'b0, w[5:0]} < nregs_lp);
      2'b01:   d.ps2pl = ({1'b0, w[5:0]} < nps2pl_lp);
      2'b10:   d.pl2ps = ({1'b0, w[5:0]} < npl2ps_lp);
      default: d.occ   = ({1'b0, w[5:0]} < npl2ps_lp);
    endcase
    return d;
  endfunction

  logic                          ready_r, aw_held, w_held;
  logic [7:0]                    aw_word_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [sw-1:0]                 wstrb_q;
  logic [31:0]                   csr_q [num_regs_p];
  logic [num_regs_p-1:0]         csr_wr_q;

  logic                          aw_hs, w_hs, ar_hs, wr_commit, wr_full_hit, wr_err;
  logic [7:0]                    wr_word;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [sw-1:0]                 wr_strb;
  dec_t                          wr_dec, rd_dec;
  logic [31:0]                   rd_data;
  logic                          rd_err;

  logic [num_ps2pl_p-1:0] ps2pl_enq, ps2pl_rdy;
  logic [cw-1:0]          ps2pl_cnt [num_ps2pl_p];
  logic [num_pl2ps_p-1:0] pl2ps_deq, pl2ps_rdy, pl2ps_v;
  logic [31:0]            pl2ps_head [num_pl2ps_p];
  logic [cw-1:0]          pl2ps_cnt [num_pl2ps_p];

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = ready_r & ~aw_held & ~s_axi_bvalid;
  assign s_axi_wready  = ready_r & ~w_held & ~s_axi_bvalid;
  assign s_axi_arready = ready_r & ~s_axi_rvalid;
  assign aw_hs         = s_axi_awvalid & s_axi_awready;
  assign w_hs          = s_axi_wvalid & s_axi_wready;
  assign ar_hs         = s_axi_arvalid & s_axi_arready;
  // Commit on the edge where both halves are either already held or handshaking now.
  assign wr_commit     = (aw_held | aw_hs) & (w_held | w_hs);
  assign wr_word       = aw_held ? aw_word_q : s_axi_awaddr[9:2];
  assign wr_data       = w_held ? wdata_q : s_axi_wdata;
  assign wr_strb       = w_held ? wstrb_q : s_axi_wstrb;
  assign wr_dec        = decode(wr_word);
  assign rd_dec        = decode(s_axi_araddr[9:2]);
  assign csr_wr_o      = csr_wr_q;
  assign pl2ps_ready_o = pl2ps_rdy & {num_pl2ps_p{ready_r}};

  always_comb begin
    ps2pl_enq   = '0;
    wr_full_hit = 1'b0;
    for (int i = 0; i < num_ps2pl_p; i++) begin
      if (wr_dec.ps2pl && wr_dec.idx == 6'(i)) begin
        ps2pl_enq[i] = wr_commit;
        wr_full_hit  = ~ps2pl_rdy[i];
      end
    end
    wr_err = ~(wr_dec.csr | wr_dec.ps2pl | wr_dec.pl2ps | wr_dec.occ) | wr_full_hit;
  end

  always_comb begin
    pl2ps_deq = '0;
    rd_data   = '0;
    rd_err    = ~(rd_dec.csr | rd_dec.ps2pl | rd_dec.pl2ps | rd_dec.occ);
    for (int k = 0; k < num_regs_p; k++)
      if (rd_dec.csr && rd_dec.idx == 6'(k)) rd_data = csr_q[k];
    for (int i = 0; i < num_ps2pl_p; i++)
      if (rd_dec.ps2pl && rd_dec.idx == 6'(i))
        rd_data = 32'(fifo_els_p) - 32'(ps2pl_cnt[i]);
    for (int i = 0; i < num_pl2ps_p; i++) begin
      if (rd_dec.pl2ps && rd_dec.idx == 6'(i)) begin
        rd_data      = pl2ps_v[i] ? pl2ps_head[i] : 32'd0;
        rd_err       = ~pl2ps_v[i];
        pl2ps_deq[i] = ar_hs;
      end
      if (rd_dec.occ && rd_dec.idx == 6'(i)) rd_data = 32'(pl2ps_cnt[i]);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_r      <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_word_q    <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= resp_okay;
      s_axi_rvalid <= 1'b0;
      s_axi_rresp  <= resp_okay;
      s_axi_rdata  <= '0;
      csr_wr_q     <= '0;
      for (int k = 0; k < num_regs_p; k++) csr_q[k] <= '0;
    end else begin
      ready_r  <= 1'b1;
      csr_wr_q <= '0;
      if (wr_commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_err ? resp_slverr : resp_okay;
        for (int k = 0; k < num_regs_p; k++) begin
          if (wr_dec.csr && wr_dec.idx == 6'(k)) begin
            csr_wr_q[k] <= 1'b1;
            for (int b = 0; b < 4; b++)
              if (wr_strb[b]) csr_q[k][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_word_q <= s_axi_awaddr[9:2];
        end
        if (w_hs) begin
          w_held  <= 1'b1;
          wdata_q <= s_axi_wdata;
          wstrb_q <= s_axi_wstrb;
        end
        if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
      end
      if (ar_hs) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_err ? resp_slverr : resp_okay;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < num_regs_p; k++) begin : g_csr
    assign csr_o[32*k +: 32] = csr_q[k];
  end

  for (genvar i = 0; i < num_ps2pl_p; i++) begin : g_ps2pl
    simple_fifo #(.els_p(fifo_els_p), .width_p(32)) u_fifo (
      .core_clk (aclk),
      .arst_n   (aresetn),
      .enq_vld  (ps2pl_enq[i]),
      .enq_dat  (wr_data[31:0]),
      .enq_rdy  (ps2pl_rdy[i]),
      .deq_vld  (ps2pl_v_o[i]),
      .deq_dat  (ps2pl_data_o[32*i +: 32]),
      .deq_rdy  (ps2pl_yumi_i[i]),
      .count    (ps2pl_cnt[i])
    );
  end

  for (genvar i = 0; i < num_pl2ps_p; i++) begin : g_pl2ps
    simple_fifo #(.els_p(fifo_els_p), .width_p(32)) u_fifo (
      .core_clk (aclk),
      .arst_n   (aresetn),
      .enq_vld  (pl2ps_v_i[i] & ready_r),
      .enq_dat  (pl2ps_data_i[32*i +: 32]),
      .enq_rdy  (pl2ps_rdy[i]),
      .deq_vld  (pl2ps_v[i]),
      .deq_dat  (pl2ps_head[i]),
      .deq_rdy  (pl2ps_deq[i]),
      .count    (pl2ps_cnt[i])
    );
  end
endmodule

// File: tb/tb_axil_csr_fifo_shell.sv
// Directed bench for axil_csr_fifo_shell; B/R responses are checked by a
// scoreboard monitor against expectations queued when each request is issued.
module tb_axil_csr_fifo_shell;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [9:0]   s_axi_awaddr, s_axi_araddr;
  logic [2:0]   s_axi_awprot, s_axi_arprot;
  logic         s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0]  s_axi_wdata, s_axi_rdata;
  logic [3:0]   s_axi_wstrb;
  logic [1:0]   s_axi_bresp, s_axi_rresp;
  logic         s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic         s_axi_rvalid, s_axi_rready;
  logic [127:0] csr_o;
  logic [3:0]   csr_wr_o;
  logic [31:0]  ps2pl_data_o, pl2ps_data_i;
  logic [0:0]   ps2pl_v_o, ps2pl_yumi_i, pl2ps_v_i, pl2ps_ready_o;

  int    n_checks = 0;
  int    n_fail = 0;
  int    wr_pulses [4];
  logic [1:0] exp_b [$];
  rexp_t      exp_r [$];

  always #5 aclk = ~aclk;

  axil_csr_fifo_shell dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .csr_o(csr_o), .csr_wr_o(csr_wr_o),
    .ps2pl_data_o(ps2pl_data_o), .ps2pl_v_o(ps2pl_v_o), .ps2pl_yumi_i(ps2pl_yumi_i),
    .pl2ps_data_i(pl2ps_data_i), .pl2ps_v_i(pl2ps_v_i), .pl2ps_ready_o(pl2ps_ready_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no handshake within 50 cycles, required one", name);
  endtask

  task automatic axi_write(input logic [7:0] word, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp);
    bit aw_done, w_done, b_done;
    exp_b.push_back(resp);
    s_axi_awaddr = {word, 2'b00}; s_axi_awvalid = 1'b1;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0;
    for (int c = 0; c < 50 && !(aw_done && w_done); c++) begin
      @(negedge aclk);
      if (s_axi_awvalid && s_axi_awready) aw_done = 1'b1;
      if (s_axi_wvalid && s_axi_wready) w_done = 1'b1;
      @(posedge aclk); #1;
      if (aw_done) s_axi_awvalid = 1'b0;
      if (w_done) s_axi_wvalid = 1'b0;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    if (!(aw_done && w_done)) timeout("aw_w_handshake");
    for (int c = 0; c < 50 && !b_done; c++) begin
      @(negedge aclk);
      if (s_axi_bvalid) b_done = 1'b1;
      @(posedge aclk); #1;
    end
    s_axi_bready = 1'b0;
    if (!b_done) timeout("b_handshake");
  endtask

  task automatic axi_read(input logic [7:0] word, input logic [31:0] data, input logic [1:0] resp);
    rexp_t e;
    bit ar_done, r_done;
    e.data = data; e.resp = resp;
    exp_r.push_back(e);
    s_axi_araddr = {word, 2'b00}; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    ar_done = 1'b0; r_done = 1'b0;
    for (int c = 0; c < 50 && !ar_done; c++) begin
      @(negedge aclk);
      if (s_axi_arready) ar_done = 1'b1;
      @(posedge aclk); #1;
    end
    s_axi_arvalid = 1'b0;
    if (!ar_done) timeout("ar_handshake");
    for (int c = 0; c < 50 && !r_done; c++) begin
      @(negedge aclk);
      if (s_axi_rvalid) r_done = 1'b1;
      @(posedge aclk); #1;
    end
    s_axi_rready = 1'b0;
    if (!r_done) timeout("r_handshake");
  endtask

  task automatic pl_enq(input logic [31:0] data);
    pl2ps_data_i = data; pl2ps_v_i = 1'b1;
    @(negedge aclk);
    check("pl2ps_ready_on_enq", pl2ps_ready_o, 1);
    @(posedge aclk); #1;
    pl2ps_v_i = 1'b0;
  endtask

  initial begin
    int base;
    rexp_t e;
    aresetn = 1'b0;
    s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    ps2pl_yumi_i = '0; pl2ps_data_i = '0; pl2ps_v_i = '0;
    for (int k = 0; k < 4; k++) wr_pulses[k] = 0;

    fork
      begin : monitor
        rexp_t re;
        logic [1:0] be;
        forever begin
          @(negedge aclk);
          for (int k = 0; k < 4; k++) if (csr_wr_o[k]) wr_pulses[k]++;
          if (aresetn && s_axi_bvalid && s_axi_bready) begin
            if (exp_b.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL bresp_unexpected: got resp %0d, required no response", s_axi_bresp);
            end else begin
              be = exp_b.pop_front();
              check("bresp", s_axi_bresp, be);
            end
          end
          if (aresetn && s_axi_rvalid && s_axi_rready) begin
            if (exp_r.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL r_unexpected: got data 0x%0h, required no response", s_axi_rdata);
            end else begin
              re = exp_r.pop_front();
              check("rdata", s_axi_rdata, re.data);
              check("rresp", s_axi_rresp, re.resp);
            end
          end
        end
      end
    join_none

    // Reset values
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", s_axi_awready, 0);
    check("rst_wready", s_axi_wready, 0);
    check("rst_arready", s_axi_arready, 0);
    check("rst_bvalid_rvalid", {s_axi_bvalid, s_axi_rvalid}, 0);
    check("rst_resp_rdata", {s_axi_bresp, s_axi_rresp, s_axi_rdata}, 0);
    check("rst_csr", csr_o, 0);
    check("rst_csr_wr", csr_wr_o, 0);
    check("rst_ps2pl_v", ps2pl_v_o, 0);
    check("rst_pl2ps_ready", pl2ps_ready_o, 0);
    @(posedge aclk); #1 aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("ready_after_rst", {s_axi_awready, s_axi_wready, s_axi_arready, pl2ps_ready_o}, 4'hF);
    @(posedge aclk); #1;

    // CSR byte strobes
    base = wr_pulses[1];
    axi_write(8'd1, 32'hAABBCCDD, 4'b0101, OKAY);
    check("csr1_pulse_once", wr_pulses[1] - base, 1);
    check("csr0_no_pulse", wr_pulses[0], 0);
    axi_read(8'd1, 32'h00BB00DD, OKAY);
    check("csr1_out", csr_o[63:32], 32'h00BB00DD);

    // W well ahead of AW, then B held off
    exp_b.push_back(OKAY);
    s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(negedge aclk);
    check("w_first_wready", s_axi_wready, 1);
    @(posedge aclk); #1 s_axi_wvalid = 1'b0;
    @(negedge aclk);
    check("w_held_wready", s_axi_wready, 0);
    check("w_held_no_bvalid", s_axi_bvalid, 0);
    repeat (2) @(posedge aclk);
    #1 s_axi_awaddr = {8'd2, 2'b00}; s_axi_awvalid = 1'b1;
    @(negedge aclk);
    check("aw_late_awready", s_axi_awready, 1);
    @(posedge aclk); #1 s_axi_awvalid = 1'b0;
    @(negedge aclk);
    check("bvalid_one_after_aw", s_axi_bvalid, 1);
    check("csr2_written", csr_o[95:64], 32'h12345678);
    check("csr2_pulse", csr_wr_o[2], 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      check("bvalid_hold", s_axi_bvalid, 1);
      check("awready_low_b_pending", s_axi_awready, 0);
    end
    @(posedge aclk); #1 s_axi_bready = 1'b1;
    @(posedge aclk); #1 s_axi_bready = 1'b0;
    @(negedge aclk);
    check("awready_after_b", {s_axi_awready, s_axi_bvalid}, 2'b10);
    @(posedge aclk); #1;

    // PS->PL fill past full, then drain from the PL side
    for (int v = 1; v <= 5; v++) axi_write(8'd64, 32'(v), 4'h0, (v == 5) ? SLVERR : OKAY);
    axi_read(8'd64, 32'd0, OKAY);
    for (int j = 1; j <= 4; j++) begin
      ps2pl_yumi_i = 1'b1;
      @(negedge aclk);
      check("ps2pl_v", ps2pl_v_o, 1);
      check("ps2pl_data", ps2pl_data_o, 32'(j));
      @(posedge aclk); #1 ps2pl_yumi_i = 1'b0;
    end
    @(negedge aclk);
    check("ps2pl_empty", ps2pl_v_o, 0);
    @(posedge aclk); #1;
    axi_read(8'd64, 32'd4, OKAY);

    // PL->PS: ignored writes, empty read, wrap
    axi_write(8'd128, 32'd99, 4'hF, OKAY);
    axi_write(8'd192, 32'd99, 4'hF, OKAY);
    axi_read(8'd192, 32'd0, OKAY);
    axi_read(8'd128, 32'd0, SLVERR);
    pl_enq(32'd10);
    for (int i = 1; i <= 5; i++) begin
      pl_enq(32'(10 + i));
      axi_read(8'd192, 32'd2, OKAY);
      axi_read(8'd128, 32'(9 + i), OKAY);
    end
    axi_read(8'd128, 32'd15, OKAY);
    axi_read(8'd128, 32'd0, SLVERR);
    axi_read(8'd192, 32'd0, OKAY);

    // Full pl2ps: PL enqueue and PS dequeue in the same cycle
    for (int i = 0; i < 4; i++) pl_enq(32'(20 + i));
    check("pl2ps_full_ready", pl2ps_ready_o, 0);
    axi_read(8'd192, 32'd4, OKAY);
    e.data = 32'd20; e.resp = OKAY;
    exp_r.push_back(e);
    s_axi_araddr = {8'd128, 2'b00}; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    pl2ps_data_i = 32'd24; pl2ps_v_i = 1'b1;
    @(negedge aclk);
    check("sim_arready", s_axi_arready, 1);
    check("sim_pl2ps_ready_low", pl2ps_ready_o, 0);
    @(posedge aclk); #1 s_axi_arvalid = 1'b0;
    @(negedge aclk);
    check("sim_pl2ps_ready_next", pl2ps_ready_o, 1);
    @(posedge aclk); #1 s_axi_rready = 1'b0; pl2ps_v_i = 1'b0;
    axi_read(8'd192, 32'd4, OKAY);
    for (int i = 1; i <= 4; i++) axi_read(8'd128, 32'(20 + i), OKAY);

    // Same-cycle AR and write commit on CSR 0
    axi_write(8'd0, 32'h11111111, 4'hF, OKAY);
    exp_b.push_back(OKAY);
    e.data = 32'h11111111; e.resp = OKAY;
    exp_r.push_back(e);
    s_axi_awaddr = '0; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h22222222; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_araddr = '0; s_axi_arvalid = 1'b1; s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    @(negedge aclk);
    check("sim_all_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    @(posedge aclk); #1 s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    @(negedge aclk);
    check("sim_b_r_valid", {s_axi_bvalid, s_axi_rvalid}, 2'b11);
    @(posedge aclk); #1 s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    axi_read(8'd0, 32'h22222222, OKAY);
    axi_write(8'd20, 32'hFFFFFFFF, 4'hF, SLVERR);

    // Reset while a B response is pending and FIFOs hold data
    pl_enq(32'd30);
    pl_enq(32'd31);
    axi_write(8'd64, 32'h55, 4'hF, OKAY);
    s_axi_awaddr = {8'd3, 2'b00}; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(posedge aclk); #1 s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(negedge aclk);
    check("pre_rst_bvalid", s_axi_bvalid, 1);
    check("pre_rst_ps2pl_v", ps2pl_v_o, 1);
    #2 aresetn = 1'b0;
    #1;
    check("mid_rst_valids", {s_axi_bvalid, s_axi_rvalid}, 0);
    check("mid_rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready, pl2ps_ready_o}, 0);
    check("mid_rst_csr", csr_o, 0);
    check("mid_rst_csr_wr", csr_wr_o, 0);
    check("mid_rst_ps2pl_v", ps2pl_v_o, 0);
    exp_b.delete();
    @(posedge aclk); #1 aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    axi_read(8'd192, 32'd0, OKAY);
    axi_read(8'd64, 32'd4, OKAY);
    axi_read(8'd3, 32'd0, OKAY);
    axi_read(8'd1, 32'd0, OKAY);
    axi_read(8'd20, 32'd0, SLVERR);

    repeat (3) @(posedge aclk);
    check("b_queue_drained", exp_b.size(), 0);
    check("r_queue_drained", exp_r.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
